// File: rtl/cpu_output_buffer.sv
// cpu_output_buffer
// Captures words presented by the CPU output port (qualified by inFlag) into a
// first-word-fall-through FIFO, then drains them to a consumer over a
// valid/ready handshake. Words that arrive while the FIFO is full are dropped,
// which raises a sticky overflow flag and a saturating drop counter.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   inFlag, inData      CPU output-valid pulse and word
//   dataOut, dataValid  head-of-FIFO word (0 when empty) and its valid flag
//   dataReady           consumer accepts the head word this cycle
//   count, full, empty  occupancy status
//   overflow, dropCount sticky drop flag and saturating drop count
//   clearOverflow       clears overflow and dropCount
module cpu_output_buffer #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int PTRWIDTH = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inFlag,
  input  logic [WIDTH-1:0]    inData,
  output logic [WIDTH-1:0]    dataOut,
  output logic                dataValid,
  input  logic                dataReady,
  output logic [PTRWIDTH:0]   count,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  input  logic                clearOverflow,
  output logic [7:0]          dropCount
);

  localparam logic [PTRWIDTH:0] C_DEPTH = (PTRWIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [PTRWIDTH-1:0] r_wrPtr;
  logic [PTRWIDTH-1:0] r_rdPtr;
  logic [PTRWIDTH:0]   r_count;
  logic                r_overflow;
  logic [7:0]          r_dropCount;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Status comes from the occupancy counter so full and empty stay
  // distinguishable when the pointers coincide.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_pop  = !w_empty && dataReady;
  assign w_push = inFlag && (!w_full || w_pop);
  assign w_drop = inFlag && w_full && !w_pop;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= inData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins: the clear is applied first and
  // the new drop is then counted on top of it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clearOverflow) begin
        r_dropCount <= 8'd1;
      end else if (r_dropCount != '1) begin
        r_dropCount <= r_dropCount + 1'b1;
      end
    end else if (clearOverflow) begin
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end
  end

  always_comb begin
    dataOut = '0;
    if (!w_empty) begin
      dataOut = r_mem[r_rdPtr];
    end
  end

  assign dataValid = !w_empty;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign dropCount = r_dropCount;

endmodule
